// File: rtl/logic_gate_unit.sv
// logic_gate_unit
//   WIDTH-bit bitwise logic unit with run-time operation select, a one-deep
//   valid/ready output register and a built-in self-test sweep that walks all
//   eight operations over the four (a,b) operand combinations and checks each
//   result against a hard-coded truth table.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   DWELL  cycles each sweep step is held before its result is checked (>= 1)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   A, B, op           operands and operation select
//                      (000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR,
//                       101 XNOR, 110 NOT A, 111 BUF A)
//   in_valid/in_ready  input handshake
//   Y, out_valid       registered result and its valid flag
//   out_ready          downstream consumes Y this cycle
//   sweep_start        self-test request, sampled only while idle
//   sweep_busy         drain or sweep in progress
//   sweep_done         one-cycle pulse when a sweep completes
//   sweep_pass         result of the last completed sweep
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic             sweep_pass
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SWEEP,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [4:0]       step_cnt;
   logic [DW-1:0]    dwell_cnt;
   logic             pass_flag;
   logic             transfer;
   logic             step_last;
   logic             step_ok;
   logic [WIDTH-1:0] sweep_res;

   function automatic logic [WIDTH-1:0] gate(input logic [2:0] f,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (f)
         3'd0:    r = a & b;
         3'd1:    r = a | b;
         3'd2:    r = a ^ b;
         3'd3:    r = ~(a & b);
         3'd4:    r = ~(a | b);
         3'd5:    r = ~(a ^ b);
         3'd6:    r = ~a;
         default: r = a;
      endcase
      return r;
   endfunction

   // Truth-table rows are written in (a,b) = 00,01,10,11 order, left to
   // right, so row bit 3 is the 00 entry; ~{a,b} selects the right bit.
   function automatic logic golden(input logic [4:0] s);
      logic [3:0] row;
      case (s[4:2])
         3'd0:    row = 4'b0001;
         3'd1:    row = 4'b0111;
         3'd2:    row = 4'b0110;
         3'd3:    row = 4'b1110;
         3'd4:    row = 4'b1000;
         3'd5:    row = 4'b1001;
         3'd6:    row = 4'b1100;
         default: row = 4'b0011;
      endcase
      return row[~s[1:0]];
   endfunction

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      sweep_busy = 1'b0;
      sweep_done = 1'b0;
      transfer   = 1'b0;
      sweep_res  = gate(step_cnt[4:2], {WIDTH{step_cnt[1]}}, {WIDTH{step_cnt[0]}});
      step_last  = (dwell_cnt == DWELL_LAST);
      step_ok    = (sweep_res == {WIDTH{golden(step_cnt)}});
      case (state)
         IDLE: begin
            in_ready = !out_valid || out_ready;
            transfer = in_valid && in_ready;
            if (sweep_start) begin
               next_state = (!out_valid && !transfer) ? SWEEP : DRAIN;
            end
         end
         DRAIN: begin
            sweep_busy = 1'b1;
            if (!out_valid || out_ready) begin
               next_state = SWEEP;
            end
         end
         SWEEP: begin
            sweep_busy = 1'b1;
            if (step_last && (step_cnt == 5'd31)) begin
               next_state = DONE;
            end
         end
         default: begin
            sweep_done = 1'b1;
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         Y          <= '0;
         out_valid  <= 1'b0;
         sweep_pass <= 1'b0;
         pass_flag  <= 1'b0;
         step_cnt   <= '0;
         dwell_cnt  <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (transfer) begin
                  Y         <= gate(op, A, B);
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            SWEEP: begin
               Y <= sweep_res;
               if (step_last) begin
                  dwell_cnt <= '0;
                  step_cnt  <= step_cnt + 5'd1;
                  if (!step_ok) begin
                     pass_flag <= 1'b0;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + DW'(1);
               end
            end
            default: begin
               Y          <= '0;
               sweep_pass <= pass_flag;
               step_cnt   <= '0;
               dwell_cnt  <= '0;
            end
         endcase
         // Entry into SWEEP (from IDLE or DRAIN) arms a fresh pass.
         if ((state != SWEEP) && (next_state == SWEEP)) begin
            pass_flag <= 1'b1;
            step_cnt  <= '0;
            dwell_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

   localparam int W  = 8;
   localparam int DW = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [2:0]   op = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] Y;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         sweep_start = 1'b0;
   logic         sweep_busy;
   logic         sweep_done;
   logic         sweep_pass;

   int n_checks = 0;
   int n_fail   = 0;

   // Spec truth table rows, (a,b) = 00,01,10,11 left to right.
   logic [3:0] tt [8];

   // Reference state of the output register.
   logic [W-1:0] exp_y;
   logic         exp_valid;

   always #5 clk = ~clk;

   logic_gate_unit #(.WIDTH(W), .DWELL(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .A           (A),
      .B           (B),
      .op          (op),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Y           (Y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done),
      .sweep_pass  (sweep_pass)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each result bit is a truth-table lookup on its (a,b) pair.
   function automatic logic [W-1:0] ref_gate(input logic [2:0] f,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      logic [3:0]   row;
      int           k;
      row = tt[f];
      for (int i = 0; i < W; i++) begin
         k = 3 - (2 * int'(a[i]) + int'(b[i]));
         r[i] = row[k];
      end
      return r;
   endfunction

   // Drive one cycle of handshake traffic and advance the reference model.
   task automatic step_io(input string tag);
      logic acc;
      #1;
      check({tag, ".in_ready"}, 32'(in_ready), 32'(!exp_valid || out_ready));
      acc = in_valid && (!exp_valid || out_ready);
      tick();
      if (acc) begin
         exp_y     = ref_gate(op, A, B);
         exp_valid = 1'b1;
      end else if (out_ready) begin
         exp_valid = 1'b0;
      end
      check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
      check({tag, ".Y"}, 32'(Y), 32'(exp_y));
   endtask

   // Called with the unit already in SWEEP; expects the full sweep, the
   // done pulse and a passing result.
   task automatic wait_sweep(input string tag);
      int n;
      n = 0;
      while (sweep_busy === 1'b1 && n < 1000) begin
         if (sweep_done !== 1'b0) begin
            check({tag, ".early_done"}, 32'(sweep_done), 32'd0);
         end
         tick();
         n++;
      end
      check({tag, ".busy_cycles"}, 32'(n), 32'(32 * DW));
      check({tag, ".done_pulse"}, 32'(sweep_done), 32'd1);
      check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
      tick();
      check({tag, ".done_low"}, 32'(sweep_done), 32'd0);
      check({tag, ".pass"}, 32'(sweep_pass), 32'd1);
      check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, ".Y_cleared"}, 32'(Y), 32'd0);
   endtask

   initial begin
      logic [W-1:0] op_exp [8];
      logic [W-1:0] first_y;
      int           dones;

      tt[0] = 4'b0001; tt[1] = 4'b0111; tt[2] = 4'b0110; tt[3] = 4'b1110;
      tt[4] = 4'b1000; tt[5] = 4'b1001; tt[6] = 4'b1100; tt[7] = 4'b0011;
      op_exp[0] = 8'hC0; op_exp[1] = 8'hFC; op_exp[2] = 8'h3C; op_exp[3] = 8'h3F;
      op_exp[4] = 8'h03; op_exp[5] = 8'hC3; op_exp[6] = 8'h0F; op_exp[7] = 8'hF0;

      // Reset state
      #12;
      check("rst.Y", 32'(Y), 32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.busy", 32'(sweep_busy), 32'd0);
      check("rst.done", 32'(sweep_done), 32'd0);
      check("rst.pass", 32'(sweep_pass), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", 32'(in_ready), 32'd1);
      exp_y = '0;
      exp_valid = 1'b0;
      tick();

      // Directed op sweep, A=F0 B=CC, back to back
      A = 8'hF0; B = 8'hCC; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         step_io("opsweep");
         check("opsweep.const", 32'(Y), 32'(op_exp[i]));
      end
      in_valid = 1'b0;
      step_io("opsweep.flush");

      // Backpressure
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; A = 8'h5A; B = 8'h0F;
      step_io("bp.first");
      first_y = Y;
      check("bp.first_val", 32'(Y), 32'h55);
      op = 3'd0; A = 8'hAA; B = 8'hFF;
      step_io("bp.hold1");
      step_io("bp.hold2");
      check("bp.Y_stable", 32'(Y), 32'(first_y));
      out_ready = 1'b1;
      step_io("bp.second");
      check("bp.second_val", 32'(Y), 32'hAA);
      in_valid = 1'b0;
      step_io("bp.flush");

      // Random traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         A = W'($urandom);
         B = W'($urandom);
         op = 3'($urandom_range(0, 7));
         in_valid = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step_io("rand");
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step_io("rand.flush");

      // Self-test from empty output register
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      check("st.busy", 32'(sweep_busy), 32'd1);
      wait_sweep("st");

      // Drain then sweep
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd1; A = 8'h12; B = 8'h40;
      tick();
      in_valid = 1'b0; sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("drain.busy", 32'(sweep_busy), 32'd1);
         check("drain.in_ready", 32'(in_ready), 32'd0);
         check("drain.out_valid", 32'(out_valid), 32'd1);
         check("drain.Y", 32'(Y), 32'h52);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("drain.out_valid_clr", 32'(out_valid), 32'd0);
      wait_sweep("drain");

      // Simultaneous in_valid and sweep_start: accepted, then drained
      out_ready = 1'b0; in_valid = 1'b1; sweep_start = 1'b1;
      op = 3'd5; A = 8'h0F; B = 8'h33;
      #1;
      check("simul.in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; sweep_start = 1'b0;
      check("simul.out_valid", 32'(out_valid), 32'd1);
      check("simul.Y", 32'(Y), 32'(ref_gate(3'd5, 8'h0F, 8'h33)));
      check("simul.busy", 32'(sweep_busy), 32'd1);
      check("simul.in_ready_drain", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      wait_sweep("simul");

      // Abort mid-sweep by asynchronous reset
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (60) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("abort.busy", 32'(sweep_busy), 32'd0);
      check("abort.pass", 32'(sweep_pass), 32'd0);
      check("abort.done", 32'(sweep_done), 32'd0);
      check("abort.Y", 32'(Y), 32'd0);
      check("abort.out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (sweep_done === 1'b1) dones++;
      end
      check("abort.no_done", 32'(dones), 32'd0);
      check("abort.idle", 32'(sweep_busy), 32'd0);
      check("abort.in_ready", 32'(in_ready), 32'd1);
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      wait_sweep("resweep");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
